// File: rtl/return_data_arbiter_rr_pkg.sv
// rtl/return_data_arbiter_rr_pkg.sv - shared defaults and arbitration mode codes for the return-data arbiter
package return_data_arbiter_rr_pkg;

    localparam int RET_FEATURE_WIDTH = 16;
    localparam int RET_CH_NUM        = 4;
    localparam int RET_FIFO_DEPTH    = 8;
    localparam int RET_AF_MARGIN     = 2;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/return_ch_fifo.sv
// rtl/return_ch_fifo.sv - single-channel synchronous FIFO with show-ahead head word
module return_ch_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/return_data_arbiter_rr.sv
// rtl/return_data_arbiter_rr.sv - per-channel FIFOs merged by fixed/round-robin arbiter into a registered valid/ready output
module return_data_arbiter_rr
    import return_data_arbiter_rr_pkg::*;
#(
    parameter int FEATURE_WIDTH = RET_FEATURE_WIDTH,
    parameter int CH_NUM        = RET_CH_NUM,
    parameter int FIFO_DEPTH    = RET_FIFO_DEPTH,
    parameter int AF_MARGIN     = RET_AF_MARGIN,
    parameter int CH_ID_W       = $clog2(CH_NUM)
) (
    input  logic                              i_system_clk,
    input  logic                              i_rst_n,
    input  logic [CH_NUM-1:0]                 i_select,
    input  logic                              i_arb_mode,
    input  logic                              i_flush,
    input  logic [CH_NUM*FEATURE_WIDTH*8-1:0] i_in_data,
    input  logic [CH_NUM-1:0]                 i_in_valid,
    output logic [CH_NUM-1:0]                 o_ch_almost_full,
    output logic [CH_NUM-1:0]                 o_ch_overflow,
    output logic [FEATURE_WIDTH*8-1:0]        o_return_data,
    output logic [CH_ID_W-1:0]                o_return_ch,
    output logic                              o_return_data_valid,
    input  logic                              i_return_data_ready
);

    localparam int DW    = FEATURE_WIDTH * 8;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(FIFO_DEPTH - AF_MARGIN);

    logic [DW-1:0]      w_head     [CH_NUM];
    logic [CNT_W-1:0]   w_count    [CH_NUM];
    logic [CNT_W-1:0]   w_cnt_next [CH_NUM];
    logic [CH_NUM-1:0]  w_empty;
    logic [CH_NUM-1:0]  w_full;
    logic [CH_NUM-1:0]  w_pop;
    logic [CH_NUM-1:0]  w_push_ok;
    logic [CH_NUM-1:0]  w_elig;
    logic [CH_ID_W-1:0] w_grant;
    logic               w_found;
    logic               w_load;
    logic [CH_ID_W-1:0] r_rr_ptr;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        return_ch_fifo #(
            .DATA_W (DW),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_system_clk),
            .i_rst_n (i_rst_n),
            .i_push  (i_in_valid[gi]),
            .i_pop   (w_pop[gi]),
            .i_flush (i_flush),
            .i_data  (i_in_data[gi*DW +: DW]),
            .o_data  (w_head[gi]),
            .o_count (w_count[gi]),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi])
        );
        assign w_push_ok[gi]  = i_in_valid[gi] & (~w_full[gi] | w_pop[gi]);
        assign w_cnt_next[gi] = w_count[gi] + CNT_W'(w_push_ok[gi]) - CNT_W'(w_pop[gi]);
    end

    // Eligibility uses the registered counts, so a word pushed this cycle waits one cycle.
    assign w_elig = i_select & ~w_empty;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        if (i_arb_mode == ARB_MODE_RR) begin
            for (int k = 1; k <= CH_NUM; k++) begin
                if (!w_found && w_elig[(int'(r_rr_ptr) + k) % CH_NUM]) begin
                    w_found = 1'b1;
                    w_grant = CH_ID_W'((int'(r_rr_ptr) + k) % CH_NUM);
                end
            end
        end else begin
            for (int k = CH_NUM - 1; k >= 0; k--) begin
                if (w_elig[k]) begin
                    w_found = 1'b1;
                    w_grant = CH_ID_W'(k);
                end
            end
        end
    end

    assign w_load = (~o_return_data_valid | i_return_data_ready) & w_found;
    assign w_pop  = w_load ? (CH_NUM'(1) << w_grant) : '0;

    always_ff @(posedge i_system_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ch_overflow    <= '0;
            o_ch_almost_full <= '0;
        end else if (i_flush) begin
            o_ch_overflow    <= '0;
            o_ch_almost_full <= '0;
        end else begin
            o_ch_overflow <= o_ch_overflow | (i_in_valid & ~w_push_ok);
            for (int k = 0; k < CH_NUM; k++) begin
                o_ch_almost_full[k] <= (w_cnt_next[k] >= AF_THRESH);
            end
        end
    end

    // Pointer starts at the last channel so the first round-robin search begins at channel 0.
    always_ff @(posedge i_system_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_return_data       <= '0;
            o_return_ch         <= '0;
            o_return_data_valid <= 1'b0;
            r_rr_ptr            <= CH_ID_W'(CH_NUM - 1);
        end else if (i_flush) begin
            o_return_data_valid <= 1'b0;
            r_rr_ptr            <= CH_ID_W'(CH_NUM - 1);
        end else if (w_load) begin
            o_return_data       <= w_head[w_grant];
            o_return_ch         <= w_grant;
            o_return_data_valid <= 1'b1;
            r_rr_ptr            <= w_grant;
        end else if (i_return_data_ready) begin
            o_return_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_return_data_arbiter_rr.sv
// tb/tb_return_data_arbiter_rr.sv - directed self-checking bench for return_data_arbiter_rr
module tb_return_data_arbiter_rr;

    logic         clk;
    logic         rst_n;
    logic [3:0]   select;
    logic         arb_mode;
    logic         flush;
    logic [511:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   almost_full;
    logic [3:0]   overflow;
    logic [127:0] ret_data;
    logic [1:0]   ret_ch;
    logic         ret_valid;
    logic         ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] q_data [$];
    logic [1:0]   q_ch   [$];

    return_data_arbiter_rr dut (
        .i_system_clk        (clk),
        .i_rst_n             (rst_n),
        .i_select            (select),
        .i_arb_mode          (arb_mode),
        .i_flush             (flush),
        .i_in_data           (in_data),
        .i_in_valid          (in_valid),
        .o_ch_almost_full    (almost_full),
        .o_ch_overflow       (overflow),
        .o_return_data       (ret_data),
        .o_return_ch         (ret_ch),
        .o_return_data_valid (ret_valid),
        .i_return_data_ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ready is changed only just after posedge, so the negedge view matches the next handshake edge.
    always @(negedge clk) begin
        if (rst_n && ret_valid && ready) begin
            q_data.push_back(ret_data);
            q_ch.push_back(ret_ch);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int c, input int w);
        logic [15:0] h;
        h = {c[7:0], w[7:0]};
        return {8{h}};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_push(input logic [3:0] mask, input int w);
        in_valid = mask;
        for (int c = 0; c < 4; c++) in_data[c*128 +: 128] = mk(c, w);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_ch.delete();
    endtask

    task automatic chk_out(input string tag, input int i, input int ch, input int w);
        logic [127:0] gd;
        logic [1:0]   gc;
        gd = (i < q_data.size()) ? q_data[i] : 'x;
        gc = (i < q_ch.size()) ? q_ch[i] : 'x;
        check($sformatf("%s_ch_%0d", tag, i), {126'b0, gc}, ch);
        check($sformatf("%s_data_%0d", tag, i), gd, mk(ch, w));
    endtask

    initial begin
        rst_n = 1'b0; select = '0; arb_mode = 1'b0; flush = 1'b0;
        in_data = '0; in_valid = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", ret_valid, 0);
        check("rst_data", ret_data, 0);
        check("rst_ch", ret_ch, 0);
        check("rst_ovf", overflow, 0);
        check("rst_af", almost_full, 0);
        rst_n = 1'b1;

        // single word latency
        select = 4'b0100; ready = 1'b1;
        step();
        set_push(4'b0100, 8'hA5);
        step();
        in_valid = '0;
        check("single_c1_valid", ret_valid, 0);
        step();
        check("single_c2_valid", ret_valid, 1);
        check("single_c2_ch", ret_ch, 2);
        check("single_c2_data", ret_data, mk(2, 8'hA5));
        step();
        check("single_c3_valid", ret_valid, 0);

        // fixed priority
        clear_q();
        select = 4'hF; arb_mode = 1'b0;
        for (int w = 0; w < 3; w++) begin set_push(4'hF, w); step(); end
        in_valid = '0;
        repeat (16) step();
        check("fixed_count", q_data.size(), 12);
        for (int n = 0; n < 12; n++) chk_out("fixed", n, n / 3, n % 3);

        // round robin
        clear_q();
        arb_mode = 1'b1;
        for (int w = 0; w < 3; w++) begin set_push(4'hF, w); step(); end
        in_valid = '0;
        repeat (16) step();
        check("rr_count", q_data.size(), 12);
        for (int n = 0; n < 12; n++) chk_out("rr", n, n % 4, n / 4);

        // round robin skipping disabled channels
        clear_q();
        select = 4'b1010;
        for (int w = 0; w < 2; w++) begin set_push(4'hF, 8'h10 + w); step(); end
        in_valid = '0;
        repeat (8) step();
        check("skip_count", q_data.size(), 4);
        for (int n = 0; n < 4; n++) chk_out("skip", n, (n % 2) ? 3 : 1, 8'h10 + n / 2);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // backpressure, fill and overflow on ch0
        clear_q();
        arb_mode = 1'b0; select = 4'b0001; ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_push(4'b0001, 8'h30 + k);
            step();
            check($sformatf("bp_af_%0d", k), almost_full[0], (k >= 6) ? 1 : 0);
            check($sformatf("bp_ovf_%0d", k), overflow[0], (k == 9) ? 1 : 0);
            if (k >= 1) check($sformatf("bp_hold_%0d", k), ret_data, mk(0, 8'h30));
        end
        in_valid = '0; ready = 1'b1;
        repeat (12) step();
        check("bp_count", q_data.size(), 9);
        for (int n = 0; n < 9; n++) chk_out("bp", n, 0, 8'h30 + n);
        check("bp_af_end", almost_full[0], 0);
        check("bp_ovf_sticky", overflow[0], 1);

        // flush during an active stream
        select = 4'hF; ready = 1'b0;
        for (int k = 0; k < 4; k++) begin set_push(4'b0100, 8'h40 + k); step(); end
        ready = 1'b1; set_push(4'b0100, 8'h44); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = '0;
        check("flush_valid", ret_valid, 0);
        check("flush_ovf", overflow, 0);
        check("flush_af", almost_full, 0);
        repeat (3) step();
        check("flush_empty", ret_valid, 0);

        // round-robin pointer restarts at channel 0 after flush
        clear_q();
        arb_mode = 1'b1;
        set_push(4'hF, 8'h50);
        step();
        in_valid = '0;
        repeat (6) step();
        check("rrflush_count", q_data.size(), 4);
        for (int n = 0; n < 4; n++) chk_out("rrflush", n, n, 8'h50);

        // full FIFO with simultaneous push and pop on ch1
        clear_q();
        arb_mode = 1'b0; select = 4'b0010; ready = 1'b0;
        for (int k = 0; k < 9; k++) begin set_push(4'b0010, 8'h60 + k); step(); end
        check("full_ovf", overflow[1], 0);
        check("full_af", almost_full[1], 1);
        ready = 1'b1;
        for (int k = 9; k < 12; k++) begin
            set_push(4'b0010, 8'h60 + k);
            step();
            check($sformatf("pp_ovf_%0d", k), overflow[1], 0);
            check($sformatf("pp_af_%0d", k), almost_full[1], 1);
        end
        in_valid = '0;
        repeat (14) step();
        check("pp_count", q_data.size(), 12);
        for (int n = 0; n < 12; n++) chk_out("pp", n, 1, 8'h60 + n);

        // asynchronous reset mid-stream
        select = 4'hF; ready = 1'b0;
        for (int k = 0; k < 8; k++) begin set_push(4'b1000, 8'h70 + k); step(); end
        in_valid = '0;
        check("pre_rst_af", almost_full[3], 1);
        check("pre_rst_valid", ret_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", ret_valid, 0);
        check("arst_data", ret_data, 0);
        check("arst_ch", ret_ch, 0);
        check("arst_af", almost_full, 0);
        @(posedge clk);
        #2 rst_n = 1'b1; ready = 1'b1;
        repeat (3) step();
        check("post_rst_valid", ret_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
